lif_neuron: RTL

LIF_NEURON -- requirements
Module: lif_neuron

---
 rtl/lif_neuron.sv | 105 ++++++++++
 1 files changed

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron with saturating membrane, live threshold/leak, and a refractory lockout.
// Latency: one cycle from input to membrane/spike. Backpressure: ready_o low while refractory; inputs are dropped there.
module lif_neuron (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  input  logic [7:0] threshold_i,
  input  logic [3:0] leak_i,
  input  logic [3:0] refractory_i,
  output logic       spike_o,
  output logic [7:0] membrane_o,
  output logic       ready_o,
  output logic [7:0] spike_count_o
);

  typedef enum logic {
    ST_INTEGRATE  = 1'b0,
    ST_REFRACTORY = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_refr_cnt;
  logic [7:0] r_membrane;
  logic       r_spike;
  logic       r_ready;
  logic [7:0] r_spike_count;

  logic [8:0] w_leaked;
  logic [8:0] w_sum_raw;
  logic [7:0] w_sum;
  logic       w_fire;

  // Leak floors at zero and the add saturates at 255; 9 bits hold the worst case 255+255.
  always_comb begin
    w_leaked  = 9'd0;
    if (r_membrane > {4'b0000, leak_i}) begin
      w_leaked = {1'b0, r_membrane - {4'b0000, leak_i}};
    end
    w_sum_raw = w_leaked + {1'b0, (valid_i ? data_i : 8'd0)};
    w_sum     = w_sum_raw[8] ? 8'hFF : w_sum_raw[7:0];
    w_fire    = (r_state == ST_INTEGRATE) && (threshold_i != 8'd0) && (w_sum >= threshold_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_INTEGRATE;
      r_refr_cnt    <= 4'd0;
      r_membrane    <= 8'd0;
      r_spike       <= 1'b0;
      r_ready       <= 1'b1;
      r_spike_count <= 8'd0;
    end else begin
      case (r_state)
        ST_INTEGRATE: begin
          if (w_fire) begin
            r_membrane    <= 8'd0;
            r_spike       <= 1'b1;
            r_spike_count <= r_spike_count + 8'd1;
            r_refr_cnt    <= refractory_i;
            if (refractory_i != 4'd0) begin
              r_state <= ST_REFRACTORY;
              r_ready <= 1'b0;
            end else begin
              r_state <= ST_INTEGRATE;
              r_ready <= 1'b1;
            end
          end else begin
            r_membrane <= w_sum;
            r_spike    <= 1'b0;
            r_state    <= ST_INTEGRATE;
            r_ready    <= 1'b1;
          end
        end
        ST_REFRACTORY: begin
          // Inputs are discarded here; the membrane stays clamped to zero and no leak applies.
          r_membrane <= 8'd0;
          r_spike    <= 1'b0;
          if (r_refr_cnt <= 4'd1) begin
            r_refr_cnt <= 4'd0;
            r_state    <= ST_INTEGRATE;
            r_ready    <= 1'b1;
          end else begin
            r_refr_cnt <= r_refr_cnt - 4'd1;
            r_state    <= ST_REFRACTORY;
            r_ready    <= 1'b0;
          end
        end
        default: begin
          r_state    <= ST_INTEGRATE;
          r_ready    <= 1'b1;
          r_membrane <= 8'd0;
          r_spike    <= 1'b0;
          r_refr_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign spike_o       = r_spike;
  assign membrane_o    = r_membrane;
  assign ready_o       = r_ready;
  assign spike_count_o = r_spike_count;

endmodule
